// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from MEM-stage resolution, plus saturating branch/mispredict statistics.
module branch_predictor #(
    parameter  int unsigned ENTRIES = 16,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [29:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      stat_br_q, stat_br_d;
    logic [31:0]      stat_mp_q, stat_mp_d;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             rd_hit, wr_hit;
    logic [1:0]       ctr_cur, ctr_d;

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign rd_idx = if_pc[IDX_W+1:2];
    assign rd_tag = if_pc[31:IDX_W+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign pred_taken   = rd_hit && ctr_q[rd_idx][1];
    assign pred_target  = rd_hit ? {target_q[rd_idx], 2'b00} : '0;
    assign pred_next_pc = pred_taken ? pred_target : if_pc + 32'd4;

    assign wr_idx = upd_pc[IDX_W+1:2];
    assign wr_tag = upd_pc[31:IDX_W+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_comb begin
        ctr_cur   = ctr_q[wr_idx];
        ctr_d     = ctr_cur;
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'd1;
        end
        if (upd_valid) begin
            if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
            if (upd_mispredict && stat_mp_q != '1) stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
            if (upd_valid) begin
                if (wr_hit) begin
                    ctr_q[wr_idx] <= ctr_d;
                    if (upd_taken) target_q[wr_idx] <= upd_target[31:2];
                end else if (upd_taken) begin
                    // Not-taken misses are never allocated; taken misses replace the entry.
                    valid_q[wr_idx]  <= 1'b1;
                    tag_q[wr_idx]    <= wr_tag;
                    target_q[wr_idx] <= upd_target[31:2];
                    ctr_q[wr_idx]    <= 2'b10;
                end
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    logic unused_low_bits;
    assign unused_low_bits = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: behavioural BTB model feeds a
// scoreboard of expected lookup/stat values, compared mid-cycle.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor #(.ENTRIES(16)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .pred_next_pc     (pred_next_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] npc;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    exp_t sb[$];

    // Reference model state, 16 entries
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_br, m_mp;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] obs_npc, obs_tgt, obs_br, obs_mp;
    logic        obs_taken;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model_lookup(input logic [31:0] pc);
        exp_t e;
        int   idx;
        logic hit;
        idx     = int'((pc >> 2) & 32'hF);
        hit     = m_valid[idx] && (m_tag[idx] == (pc >> 6));
        e.taken = hit && (m_ctr[idx] >= 2);
        e.tgt   = hit ? m_tgt[idx] : 32'h0;
        e.npc   = e.taken ? e.tgt : pc + 32'd4;
        e.br    = m_br;
        e.mp    = m_mp;
        return e;
    endfunction

    task automatic model_update(input logic rst, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic um);
        int   idx;
        logic hit;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_tag[i]   = '0;
                m_tgt[i]   = '0;
                m_ctr[i]   = 1;
            end
            m_br = '0;
            m_mp = '0;
        end else if (uv) begin
            if (m_br != 32'hFFFFFFFF) m_br = m_br + 1;
            if (um && m_mp != 32'hFFFFFFFF) m_mp = m_mp + 1;
            idx = int'((upc >> 2) & 32'hF);
            hit = m_valid[idx] && (m_tag[idx] == (upc >> 6));
            if (hit) begin
                if (ut) begin
                    if (m_ctr[idx] < 3) m_ctr[idx]++;
                    m_tgt[idx] = utgt & 32'hFFFFFFFC;
                end else if (m_ctr[idx] > 0) begin
                    m_ctr[idx]--;
                end
            end else if (ut) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = upc >> 6;
                m_tgt[idx]   = utgt & 32'hFFFFFFFC;
                m_ctr[idx]   = 2;
            end
        end
    endtask

    // One clock: drive at negedge, compare lookup/stats mid-cycle, train model at posedge.
    task automatic cycle(input logic [31:0] pc, input logic rst, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic um);
        exp_t e;
        @(negedge CLK);
        if_pc          = pc;
        nRST           = ~rst;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = um;
        sb.push_back(model_lookup(pc));
        #1;
        obs_taken = pred_taken;
        obs_tgt   = pred_target;
        obs_npc   = pred_next_pc;
        obs_br    = stat_branches;
        obs_mp    = stat_mispredicts;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("pred_taken",   {31'd0, obs_taken}, {31'd0, e.taken});
            check("pred_target",  obs_tgt, e.tgt);
            check("pred_next_pc", obs_npc, e.npc);
            check("stat_br",      obs_br, e.br);
            check("stat_mp",      obs_mp, e.mp);
        end
        @(posedge CLK);
        model_update(rst, uv, upc, ut, utgt, um);
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic um);
        cycle(pc, 1'b0, 1'b1, upc, ut, utgt, um);
    endtask

    logic [31:0] pcs [8];

    initial begin
        pcs[0] = 32'h40;  pcs[1] = 32'h440; pcs[2] = 32'h80;  pcs[3] = 32'hC4;
        pcs[4] = 32'h7C;  pcs[5] = 32'h840; pcs[6] = 32'h1003C; pcs[7] = 32'hFFFFFFFC;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_br = '0; m_mp = '0;
        nRST = 1'b0; if_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

        // Reset state
        cycle(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cycle(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("reset_npc", obs_npc, 32'h44);
        check("reset_tgt", obs_tgt, 32'h0);

        // First allocation with mispredict
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b1);
        look(32'h40);
        check("alloc_npc", obs_npc, 32'h100);
        check("alloc_br",  obs_br,  32'd1);
        check("alloc_mp",  obs_mp,  32'd1);

        // Counter saturation
        repeat (4) upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("ctr10_taken", {31'd0, obs_taken}, 32'd1);
        upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("ctr00_npc", obs_npc, 32'h44);
        check("ctr00_tgt", obs_tgt, 32'h100);
        upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);

        // Aliasing and replacement
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h440);
        check("alias_miss", obs_npc, 32'h444);
        upd(32'h440, 32'h440, 1'b1, 32'h200, 1'b1);
        look(32'h40);
        check("replaced_miss", obs_npc, 32'h44);
        look(32'h440);
        check("replaced_hit", obs_npc, 32'h200);
        upd(32'h840, 32'hC8, 1'b0, 32'h500, 1'b0);
        look(32'hC8);
        check("nt_no_alloc", obs_npc, 32'hCC);

        // Same-cycle lookup and update
        upd(32'h80, 32'h80, 1'b1, 32'h300, 1'b0);
        check("raw_no_bypass", obs_npc, 32'h84);
        look(32'h80);
        check("raw_next", obs_npc, 32'h300);

        // Wrap-around and ignored mispredict without valid
        look(32'hFFFFFFFC);
        check("wrap_npc", obs_npc, 32'h0);
        cycle(32'h40, 1'b0, 1'b0, 32'h40, 1'b1, 32'h100, 1'b1);
        look(32'h40);

        // Randomised training over aliasing PCs
        for (int n = 0; n < 300; n++) begin
            cycle(pcs[$urandom_range(0, 7)], 1'b0, 1'($urandom_range(0, 1)),
                  pcs[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                  {$urandom_range(0, 255), 2'($urandom_range(0, 3)), 2'b00} | 32'h1000,
                  1'($urandom_range(0, 1)));
        end

        // Mid-operation reset with a dropped update
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h80, 32'h80, 1'b1, 32'h300, 1'b1);
        cycle(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
        look(32'h40);
        check("midrst_drop", obs_npc, 32'h44);
        check("midrst_br",   obs_br,  32'd0);
        look(32'h80);
        look(32'h440);

        // Statistics saturation
        #1;
        force dut.stat_br_q = 32'hFFFFFFFF;
        force dut.stat_mp_q = 32'hFFFFFFFF;
        #1;
        release dut.stat_br_q;
        release dut.stat_mp_q;
        m_br = 32'hFFFFFFFF;
        m_mp = 32'hFFFFFFFF;
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b1);
        look(32'h40);
        check("sat_br", obs_br, 32'hFFFFFFFF);
        check("sat_mp", obs_mp, 32'hFFFFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
